// File: rtl/btn_if.sv
// Button conditioning bus: raw pads in, debounced level and press/release pulses out.
interface btn_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             btn_any;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_any
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_any
    );
endinterface

// File: rtl/btn_pulse_cond.sv
// Per-lane pad synchroniser, debouncer and press/release pulse generator.
// Optional auto-repeat of press pulses while held: define AUTO_REPEAT_EN.
module btn_pulse_cond #(
    parameter int N_BTN         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 1250000,
    parameter int REPEAT_DELAY  = 62500000,
    parameter int REPEAT_PERIOD = 25000000
) (
    input  logic clk,
    input  logic rst,
    btn_if.slave bus
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
`endif

    if (SYNC_STAGES < 2 || DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("btn_pulse_cond: illegal parameter set");
    end

    logic [N_BTN-1:0] level_reg;
    logic [N_BTN-1:0] level_next;
    logic [N_BTN-1:0] press_reg;
    logic [N_BTN-1:0] press_next;
    logic [N_BTN-1:0] release_reg;
    logic [N_BTN-1:0] release_next;
    logic             any_reg;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_lane
        logic [SYNC_STAGES-1:0] sync_reg;
        logic [CW-1:0]          cnt_reg;
        logic [CW-1:0]          cnt_next;
        logic                   s;
        logic                   lvl_nx;
        logic                   rise;
        logic                   fall;

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_reg <= '0;
                cnt_reg  <= '0;
            end else begin
                sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.btn_in[gi]};
                cnt_reg  <= cnt_next;
            end
        end

        assign s = sync_reg[SYNC_STAGES-1];

        // Any return to the accepted level restarts the stability count.
        always_comb begin
            cnt_next = cnt_reg;
            lvl_nx   = level_reg[gi];
            if (s == level_reg[gi]) begin
                cnt_next = '0;
            end else if (cnt_reg == CNT_LAST) begin
                lvl_nx   = s;
                cnt_next = '0;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end

        assign rise             = lvl_nx & ~level_reg[gi];
        assign fall             = ~lvl_nx & level_reg[gi];
        assign level_next[gi]   = lvl_nx;
        assign release_next[gi] = fall;

`ifdef AUTO_REPEAT_EN
        logic [RW-1:0] rep_cnt_reg;
        logic [RW-1:0] rep_cnt_next;
        logic          rep_first_reg;
        logic          rep_first_next;
        logic          rep_fire;

        always_ff @(posedge clk) begin
            if (rst) begin
                rep_cnt_reg   <= '0;
                rep_first_reg <= 1'b0;
            end else begin
                rep_cnt_reg   <= rep_cnt_next;
                rep_first_reg <= rep_first_next;
            end
        end

        // Repeats only fire while the level is held across the edge, so a falling edge suppresses them.
        always_comb begin
            rep_cnt_next   = rep_cnt_reg;
            rep_first_next = rep_first_reg;
            rep_fire       = 1'b0;
            if (rise) begin
                rep_cnt_next   = '0;
                rep_first_next = 1'b1;
            end else if (level_reg[gi] && lvl_nx) begin
                if (rep_cnt_reg == (rep_first_reg ? DELAY_LAST : PERIOD_LAST)) begin
                    rep_fire       = 1'b1;
                    rep_cnt_next   = '0;
                    rep_first_next = 1'b0;
                end else begin
                    rep_cnt_next = rep_cnt_reg + RW'(1);
                end
            end else begin
                rep_cnt_next   = '0;
                rep_first_next = 1'b0;
            end
        end

        assign press_next[gi] = rise | rep_fire;
`else
        assign press_next[gi] = rise;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_reg   <= '0;
            press_reg   <= '0;
            release_reg <= '0;
            any_reg     <= 1'b0;
        end else begin
            level_reg   <= level_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            any_reg     <= |press_next;
        end
    end

    assign bus.btn_level   = level_reg;
    assign bus.btn_press   = press_reg;
    assign bus.btn_release = release_reg;
    assign bus.btn_any     = any_reg;

endmodule
